// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port fixed-priority arbiter with port-1 starvation guard in front of a single-port block RAM
module ram_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  p0_req,
  input  logic [3:0]            p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [31:0]           p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  input  logic                  p1_req,
  input  logic [3:0]            p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [31:0]           p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [31:0]           rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  output logic [3:0]            ram_we,
  input  logic [31:0]           ram_dout
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]            starve_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           din_q;
  logic                  rd0_q;
  logic                  rd1_q;
  logic                  force_p1;

  always_comb begin
    force_p1 = (starve_cnt == LIMIT);
    p0_gnt   = 1'b0;
    p1_gnt   = 1'b0;
    if (!rsta) begin
      if (p0_req && !(p1_req && force_p1))
        p0_gnt = 1'b1;
      else if (p1_req)
        p1_gnt = 1'b1;
    end
  end

  // Address and data hold their last driven value when idle so the RAM pins stay quiet.
  always_comb begin
    ram_addr = addr_q;
    ram_din  = din_q;
    ram_we   = 4'b0000;
    if (p0_gnt) begin
      ram_addr = p0_addr;
      ram_din  = p0_wdata;
      ram_we   = p0_we;
    end else if (p1_gnt) begin
      ram_addr = p1_addr;
      ram_din  = p1_wdata;
      ram_we   = p1_we;
    end
  end

  always_ff @(posedge clka) begin
    addr_q <= ram_addr;
    din_q  <= ram_din;
    if (rsta) begin
      starve_cnt <= 4'd0;
      rd0_q      <= 1'b0;
      rd1_q      <= 1'b0;
    end else begin
      rd0_q <= p0_gnt && (p0_we == 4'b0000);
      rd1_q <= p1_gnt && (p1_we == 4'b0000);
      if (!p1_req || p1_gnt)
        starve_cnt <= 4'd0;
      else if (starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Gated by rsta so a read granted just before reset never reports data.
  assign p0_rvalid = rd0_q & ~rsta;
  assign p1_rvalid = rd1_q & ~rsta;
  assign rdata     = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - bench for ram_arbiter with a behavioural RAM and arbitration model
module tb_ram_arbiter;
  localparam int AW = 14;
  localparam int LIM = 4;

  logic          clka = 1'b0;
  logic          rsta;
  logic          p0_req, p1_req;
  logic [3:0]    p0_we, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [31:0]   p0_wdata, p1_wdata;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0]   rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_we;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:255];
  logic [31:0] refmem [0:255];

  ram_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
    .clka(clka), .rsta(rsta),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  always #5 clka = ~clka;

  always @(posedge clka) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_din[8*b +: 8];
    ram_dout <= mem[ram_addr[7:0]];
  end

  task automatic nxt();
    @(posedge clka); #1;
  endtask

  task automatic smp();
    @(negedge clka);
  endtask

  task automatic set_p0(input logic r, input logic [3:0] w, input logic [AW-1:0] a, input logic [31:0] d);
    p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d;
  endtask

  task automatic set_p1(input logic r, input logic [3:0] w, input logic [AW-1:0] a, input logic [31:0] d);
    p1_req = r; p1_we = w; p1_addr = a; p1_wdata = d;
  endtask

  task automatic test_reset();
    rsta = 1'b1;
    set_p0(1'b1, 4'hF, 14'h1, 32'h1);
    set_p1(1'b1, 4'h0, 14'h2, 32'h2);
    smp();
    checks++; if ({p0_gnt, p1_gnt} !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", {p0_gnt, p1_gnt}); end
    checks++; if (ram_we !== 4'h0) begin failures++; $display("FAIL reset_we got=%h exp=0", ram_we); end
    nxt();
    smp();
    checks++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin failures++; $display("FAIL reset_rvalid got=%b exp=00", {p0_rvalid, p1_rvalid}); end
    set_p0(1'b0, 4'h0, '0, '0);
    set_p1(1'b0, 4'h0, '0, '0);
    nxt();
    rsta = 1'b0;
    nxt();
  endtask

  task automatic test_p0_write_read();
    set_p0(1'b1, 4'hF, 14'h10, 32'hDEADBEEF);
    smp();
    checks++; if (p0_gnt !== 1'b1 || ram_we !== 4'hF || ram_addr !== 14'h10 || ram_din !== 32'hDEADBEEF) begin
      failures++; $display("FAIL p0_write gnt=%b we=%h addr=%h din=%h exp 1 f 0010 deadbeef", p0_gnt, ram_we, ram_addr, ram_din); end
    nxt();
    set_p0(1'b1, 4'h0, 14'h10, 32'h0);
    smp();
    checks++; if (p0_gnt !== 1'b1 || p0_rvalid !== 1'b0) begin failures++; $display("FAIL p0_read_gnt gnt=%b rvalid=%b exp 1 0", p0_gnt, p0_rvalid); end
    nxt();
    set_p0(1'b0, 4'hF, 14'h3F, 32'hFFFFFFFF);
    smp();
    checks++; if (p0_rvalid !== 1'b1 || rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL p0_read_data rvalid=%b rdata=%h exp 1 deadbeef", p0_rvalid, rdata); end
    checks++; if (p1_rvalid !== 1'b0 || p0_gnt !== 1'b0) begin failures++; $display("FAIL p0_idle p1_rvalid=%b p0_gnt=%b exp 0 0", p1_rvalid, p0_gnt); end
    checks++; if (ram_we !== 4'h0 || ram_addr !== 14'h10 || ram_din !== 32'h0) begin
      failures++; $display("FAIL idle_hold we=%h addr=%h din=%h exp 0 0010 00000000", ram_we, ram_addr, ram_din); end
    nxt();
    smp();
    checks++; if (p0_rvalid !== 1'b0) begin failures++; $display("FAIL p0_rvalid_once got=%b exp=0", p0_rvalid); end
    nxt();
  endtask

  task automatic test_byte_write();
    set_p1(1'b1, 4'hF, 14'h20, 32'h11223344);
    smp();
    checks++; if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin failures++; $display("FAIL p1_full_write gnt1=%b gnt0=%b exp 1 0", p1_gnt, p0_gnt); end
    nxt();
    set_p1(1'b1, 4'b0001, 14'h20, 32'h000000AA);
    smp();
    checks++; if (ram_we !== 4'b0001 || ram_din !== 32'h000000AA) begin failures++; $display("FAIL p1_byte_we we=%h din=%h exp 1 000000aa", ram_we, ram_din); end
    nxt();
    set_p1(1'b1, 4'h0, 14'h20, 32'h0);
    nxt();
    set_p1(1'b0, 4'h0, 14'h0, 32'h0);
    smp();
    checks++; if (p1_rvalid !== 1'b1 || rdata !== 32'h112233AA || p0_rvalid !== 1'b0) begin
      failures++; $display("FAIL byte_merge rvalid=%b rdata=%h p0_rvalid=%b exp 1 112233aa 0", p1_rvalid, rdata, p0_rvalid); end
    nxt();
  endtask

  task automatic test_simultaneous();
    set_p0(1'b1, 4'hF, 14'h30, 32'h5A5A0001);
    set_p1(1'b1, 4'h0, 14'h30, 32'h0);
    smp();
    checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin failures++; $display("FAIL simul_first got=%b exp=10", {p0_gnt, p1_gnt}); end
    nxt();
    p0_req = 1'b0;
    smp();
    checks++; if ({p0_gnt, p1_gnt} !== 2'b01 || ram_addr !== 14'h30 || ram_we !== 4'h0) begin
      failures++; $display("FAIL simul_second gnt=%b addr=%h we=%h exp 01 0030 0", {p0_gnt, p1_gnt}, ram_addr, ram_we); end
    nxt();
    p1_req = 1'b0;
    smp();
    checks++; if (p1_rvalid !== 1'b1 || rdata !== 32'h5A5A0001) begin failures++; $display("FAIL simul_data rvalid=%b rdata=%h exp 1 5a5a0001", p1_rvalid, rdata); end
    nxt();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      set_p0(1'b0, 4'($urandom), AW'($urandom), $urandom);
      set_p1(1'b0, 4'($urandom), AW'($urandom), $urandom);
      smp();
      checks++; if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid} !== 4'b0 || ram_we !== 4'h0) begin
        failures++; $display("FAIL idle_%0d gnt/rv=%b we=%h exp 0000 0", i, {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}, ram_we); end
      nxt();
    end
  endtask

  task automatic test_starvation();
    logic [1:0] exp;
    for (int i = 0; i < 15; i++) begin
      set_p0(1'b1, 4'h0, AW'(i), 32'h0);
      set_p1(1'b1, 4'h0, AW'(i + 1), 32'h0);
      exp = (i % (LIM + 1) == LIM) ? 2'b01 : 2'b10;
      smp();
      checks++; if ({p0_gnt, p1_gnt} !== exp) begin failures++; $display("FAIL starve_%0d got=%b exp=%b", i, {p0_gnt, p1_gnt}, exp); end
      nxt();
    end
    set_p0(1'b0, 4'h0, '0, '0);
    set_p1(1'b0, 4'h0, '0, '0);
    nxt();
  endtask

  task automatic test_reset_mid();
    set_p0(1'b0, 4'h0, '0, '0);
    set_p1(1'b1, 4'h0, 14'h20, 32'h0);
    smp();
    checks++; if (p1_gnt !== 1'b1) begin failures++; $display("FAIL mid_gnt got=%b exp=1", p1_gnt); end
    nxt();
    rsta = 1'b1;
    set_p0(1'b1, 4'hF, 14'h21, 32'h12345678);
    for (int i = 0; i < 2; i++) begin
      smp();
      checks++; if ({p0_gnt, p1_gnt, p1_rvalid} !== 3'b000 || ram_we !== 4'h0) begin
        failures++; $display("FAIL mid_rst_%0d gnt/rv=%b we=%h exp 000 0", i, {p0_gnt, p1_gnt, p1_rvalid}, ram_we); end
      nxt();
    end
    rsta = 1'b0;
    set_p0(1'b1, 4'h0, 14'h21, 32'h0);
    for (int i = 0; i < 5; i++) begin
      smp();
      checks++; if ({p0_gnt, p1_gnt} !== ((i == LIM) ? 2'b01 : 2'b10)) begin
        failures++; $display("FAIL mid_after_%0d got=%b exp=%b", i, {p0_gnt, p1_gnt}, (i == LIM) ? 2'b01 : 2'b10); end
      nxt();
    end
    set_p0(1'b0, 4'h0, '0, '0);
    set_p1(1'b0, 4'h0, '0, '0);
    nxt();
  endtask

  task automatic test_random();
    int starve = 0;
    int win;
    bit pend0 = 0, pend1 = 0, known = 0;
    logic [31:0] pend_data = '0, last_din = '0;
    logic [AW-1:0] last_addr = '0;
    logic [3:0] ewe;
    logic [AW-1:0] eaddr;
    logic [31:0] edin;
    for (int a = 0; a < 256; a++) refmem[a] = mem[a];
    rsta = 1'b1;
    nxt();
    rsta = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!p0_req && $urandom_range(0, 9) < 6)
        set_p0(1'b1, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom), AW'($urandom_range(0, 15)), $urandom);
      if (!p1_req && $urandom_range(0, 9) < 6)
        set_p1(1'b1, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom), AW'($urandom_range(0, 15)), $urandom);
      rsta = ($urandom_range(0, 39) == 0);
      smp();
      // Port 0 has priority unless port 1 has already waited the limit.
      if (rsta) win = -1;
      else if (p0_req && p1_req) win = (starve == LIM) ? 1 : 0;
      else if (p0_req) win = 0;
      else if (p1_req) win = 1;
      else win = -1;
      ewe = 4'h0; eaddr = last_addr; edin = last_din;
      if (win == 0) begin ewe = p0_we; eaddr = p0_addr; edin = p0_wdata; end
      if (win == 1) begin ewe = p1_we; eaddr = p1_addr; edin = p1_wdata; end
      checks++; if (p0_gnt !== (win == 0) || p1_gnt !== (win == 1)) begin
        failures++; $display("FAIL rnd_gnt c=%0d got=%b%b exp=%b%b", c, p0_gnt, p1_gnt, win == 0, win == 1); end
      checks++; if (ram_we !== ewe) begin failures++; $display("FAIL rnd_we c=%0d got=%h exp=%h", c, ram_we, ewe); end
      if (known || win >= 0) begin
        checks++; if (ram_addr !== eaddr || ram_din !== edin) begin
          failures++; $display("FAIL rnd_bus c=%0d addr=%h din=%h exp %h %h", c, ram_addr, ram_din, eaddr, edin); end
      end
      checks++; if (p0_rvalid !== (pend0 && !rsta) || p1_rvalid !== (pend1 && !rsta)) begin
        failures++; $display("FAIL rnd_rvalid c=%0d got=%b%b exp=%b%b", c, p0_rvalid, p1_rvalid, pend0 && !rsta, pend1 && !rsta); end
      if ((pend0 || pend1) && !rsta) begin
        checks++; if (rdata !== pend_data) begin failures++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, rdata, pend_data); end
      end
      pend0 = (win == 0) && (ewe == 4'h0);
      pend1 = (win == 1) && (ewe == 4'h0);
      if (win >= 0) begin
        known = 1; last_addr = eaddr; last_din = edin;
        pend_data = refmem[eaddr[7:0]];
        for (int b = 0; b < 4; b++) if (ewe[b]) refmem[eaddr[7:0]][8*b +: 8] = edin[8*b +: 8];
      end
      if (rsta || !p1_req || win == 1) starve = 0;
      else if (starve < LIM) starve++;
      nxt();
      if (win == 0) p0_req = 1'b0;
      if (win == 1) p1_req = 1'b0;
    end
    rsta = 1'b0;
    set_p0(1'b0, 4'h0, '0, '0);
    set_p1(1'b0, 4'h0, '0, '0);
    nxt();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    rsta = 1'b1;
    set_p0(1'b0, 4'h0, '0, '0);
    set_p1(1'b0, 4'h0, '0, '0);
    nxt();
    test_reset();
    test_p0_write_read();
    test_byte_write();
    test_simultaneous();
    test_idle();
    test_starvation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
